// File: rtl/ampliacao_pixel_escalavel_pkg.sv
// Shared types and width helpers for the nearest-neighbour pixel upscaler.
package ampliacao_pkg;

    typedef enum logic {
        R_OCIOSO   = 1'b0,
        R_ENVIANDO = 1'b1
    } estado_leitor_t;

    function automatic int larg_fator(input int fator_max);
        return $clog2(fator_max + 1);
    endfunction

    function automatic int larg_x(input int largura);
        return (largura > 1) ? $clog2(largura) : 1;
    endfunction

    function automatic int larg_y(input int altura);
        return (altura > 1) ? $clog2(altura) : 1;
    endfunction

    // Out-of-range requests (0 or above the supported maximum) fall back to no scaling.
    function automatic int sanear_fator(input int fator, input int fator_max);
        if ((fator == 0) || (fator > fator_max)) begin
            return 1;
        end else begin
            return fator;
        end
    endfunction

endpackage

// File: rtl/ampliacao_pixel_escalavel_banco_linha.sv
// One input line of pixels: synchronous write port, asynchronous read port, no reset on contents.
module banco_linha #(
    parameter int LARGURA_PIXEL = 8,
    parameter int PROFUNDIDADE  = 160,
    parameter int LARG_END      = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [LARG_END-1:0]      waddr,
    input  logic [LARGURA_PIXEL-1:0] wdata,
    input  logic [LARG_END-1:0]      raddr,
    output logic [LARGURA_PIXEL-1:0] rdata
);

    logic [LARGURA_PIXEL-1:0] mem_r [PROFUNDIDADE];

    // Pixel storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/ampliacao_pixel_escalavel.sv
// Streaming nearest-neighbour upscaler: ping-pong line banks, per-line scale factor,
// ready/valid on both sides and a registered output stage.
module ampliacao_pixel_escalavel
    import ampliacao_pkg::*;
#(
    parameter int LARGURA_PIXEL  = 8,
    parameter int LARGURA_IMAGEM = 160,
    parameter int ALTURA_IMAGEM  = 120,
    parameter int FATOR_MAX      = 4,
    parameter int LARGURA_MAXIMA = 320
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [$clog2(FATOR_MAX+1)-1:0]   fator,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LARGURA_PIXEL-1:0]         in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LARGURA_PIXEL-1:0]         out_data,
    output logic                             out_eol,
    output logic                             out_eof
);

    localparam int LF = larg_fator(FATOR_MAX);
    localparam int LX = larg_x(LARGURA_IMAGEM);
    localparam int LY = larg_y(ALTURA_IMAGEM);
    localparam logic [LX-1:0] X_ULT = LX'(LARGURA_IMAGEM - 1);
    localparam logic [LY-1:0] Y_ULT = LY'(ALTURA_IMAGEM - 1);
    localparam logic [LF-1:0] F_UM  = LF'(1);

    if (LARGURA_IMAGEM * FATOR_MAX > LARGURA_MAXIMA) begin : g_largura_excedida
        $fatal(1, "ampliacao_pixel_escalavel: LARGURA_IMAGEM*FATOR_MAX exceeds LARGURA_MAXIMA");
    end

    logic [1:0]               cheio_r;
    logic [1:0]               enche_s;
    logic [1:0]               esvazia_s;
    logic                     wr_sel_r;
    logic                     rd_sel_r;
    logic [LX-1:0]            x_in_r;
    logic [LY-1:0]            y_in_r;
    logic [LF-1:0]            fator_banco_r [2];
    logic [LY-1:0]            y_banco_r [2];
    logic [LF-1:0]            fator_limpo_s;
    logic                     aceita_s;
    logic                     fim_linha_in_s;
    logic [1:0]               we_s;
    logic [LARGURA_PIXEL-1:0] rdata_s [2];

    estado_leitor_t           estado_r;
    estado_leitor_t           prox_estado_s;
    logic [LX-1:0]            x_out_r;
    logic [LF-1:0]            rep_x_r;
    logic [LF-1:0]            rep_y_r;
    logic [LX-1:0]            nx_s;
    logic [LF-1:0]            nrx_s;
    logic [LF-1:0]            nry_s;
    logic                     nbanco_s;
    logic                     carrega_s;
    logic                     libera_s;
    logic                     ultimo_s;
    logic [LF-1:0]            f_atual_s;
    logic [LF-1:0]            f_prox_s;
    logic [LY-1:0]            y_prox_s;
    logic [LARGURA_PIXEL-1:0] dado_prox_s;
    logic                     eol_prox_s;
    logic                     eof_prox_s;

    logic                     out_valid_r;
    logic [LARGURA_PIXEL-1:0] out_data_r;
    logic                     out_eol_r;
    logic                     out_eof_r;

    assign in_ready       = ~cheio_r[wr_sel_r];
    assign aceita_s       = in_valid & ~cheio_r[wr_sel_r];
    assign fim_linha_in_s = aceita_s & (x_in_r == X_ULT);
    assign fator_limpo_s  = LF'(sanear_fator(int'(fator), FATOR_MAX));
    assign we_s           = {aceita_s & wr_sel_r, aceita_s & ~wr_sel_r};

    for (genvar g = 0; g < 2; g++) begin : g_banco
        banco_linha #(
            .LARGURA_PIXEL (LARGURA_PIXEL),
            .PROFUNDIDADE  (LARGURA_IMAGEM),
            .LARG_END      (LX)
        ) u_banco (
            .clk   (clk),
            .we    (we_s[g]),
            .waddr (x_in_r),
            .wdata (in_data),
            .raddr (nx_s),
            .rdata (rdata_s[g])
        );
    end

    // Writer side: column/line counters plus the per-bank factor and line index.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_sel_r <= 1'b0;
            x_in_r   <= LX'(0);
            y_in_r   <= LY'(0);
            for (int i = 0; i < 2; i++) begin
                fator_banco_r[i] <= F_UM;
                y_banco_r[i]     <= LY'(0);
            end
        end else if (aceita_s) begin
            if (x_in_r == LX'(0)) begin
                fator_banco_r[wr_sel_r] <= fator_limpo_s;
            end
            if (x_in_r == X_ULT) begin
                x_in_r              <= LX'(0);
                wr_sel_r            <= ~wr_sel_r;
                y_banco_r[wr_sel_r] <= y_in_r;
                y_in_r              <= (y_in_r == Y_ULT) ? LY'(0) : y_in_r + LY'(1);
            end else begin
                x_in_r <= x_in_r + LX'(1);
            end
        end
    end

    // Bank-full flags: writer fills one bank while the reader may release the other.
    always_comb begin
        enche_s   = 2'b00;
        esvazia_s = 2'b00;
        if (fim_linha_in_s) begin
            enche_s = wr_sel_r ? 2'b10 : 2'b01;
        end else begin
            enche_s = 2'b00;
        end
        if (libera_s) begin
            esvazia_s = rd_sel_r ? 2'b10 : 2'b01;
        end else begin
            esvazia_s = 2'b00;
        end
    end

    // Bank-full flag register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cheio_r <= 2'b00;
        end else begin
            cheio_r <= (cheio_r | enche_s) & ~esvazia_s;
        end
    end

    // Reader next-state: which pixel position (and bank) the output register shows next.
    always_comb begin
        prox_estado_s = estado_r;
        carrega_s     = 1'b0;
        libera_s      = 1'b0;
        nbanco_s      = rd_sel_r;
        nx_s          = x_out_r;
        nrx_s         = rep_x_r;
        nry_s         = rep_y_r;
        f_atual_s     = fator_banco_r[rd_sel_r];
        ultimo_s      = out_eol_r & (rep_y_r == f_atual_s - F_UM);
        case (estado_r)
            R_OCIOSO: begin
                if (cheio_r[rd_sel_r]) begin
                    prox_estado_s = R_ENVIANDO;
                    carrega_s     = 1'b1;
                    nx_s          = LX'(0);
                    nrx_s         = LF'(0);
                    nry_s         = LF'(0);
                end else begin
                    prox_estado_s = R_OCIOSO;
                end
            end
            R_ENVIANDO: begin
                if (out_valid_r && out_ready) begin
                    if (ultimo_s) begin
                        libera_s = 1'b1;
                        nbanco_s = ~rd_sel_r;
                        nx_s     = LX'(0);
                        nrx_s    = LF'(0);
                        nry_s    = LF'(0);
                        // Chain straight into the other bank when it is already full.
                        if (cheio_r[~rd_sel_r]) begin
                            prox_estado_s = R_ENVIANDO;
                            carrega_s     = 1'b1;
                        end else begin
                            prox_estado_s = R_OCIOSO;
                        end
                    end else begin
                        carrega_s = 1'b1;
                        if (rep_x_r != f_atual_s - F_UM) begin
                            nrx_s = rep_x_r + F_UM;
                        end else begin
                            nrx_s = LF'(0);
                            if (x_out_r != X_ULT) begin
                                nx_s = x_out_r + LX'(1);
                            end else begin
                                nx_s  = LX'(0);
                                nry_s = rep_y_r + F_UM;
                            end
                        end
                    end
                end else begin
                    prox_estado_s = R_ENVIANDO;
                end
            end
            default: begin
                prox_estado_s = R_OCIOSO;
            end
        endcase
    end

    // Output-pixel attributes for the position selected above.
    always_comb begin
        f_prox_s    = fator_banco_r[nbanco_s];
        y_prox_s    = y_banco_r[nbanco_s];
        dado_prox_s = rdata_s[nbanco_s];
        eol_prox_s  = (nx_s == X_ULT) & (nrx_s == f_prox_s - F_UM);
        eof_prox_s  = eol_prox_s & (nry_s == f_prox_s - F_UM) & (y_prox_s == Y_ULT);
    end

    // Reader state, position counters and registered output stage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            estado_r    <= R_OCIOSO;
            rd_sel_r    <= 1'b0;
            x_out_r     <= LX'(0);
            rep_x_r     <= LF'(0);
            rep_y_r     <= LF'(0);
            out_valid_r <= 1'b0;
            out_data_r  <= LARGURA_PIXEL'(0);
            out_eol_r   <= 1'b0;
            out_eof_r   <= 1'b0;
        end else begin
            estado_r <= prox_estado_s;
            if (libera_s) begin
                rd_sel_r <= ~rd_sel_r;
            end
            if (carrega_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= dado_prox_s;
                out_eol_r   <= eol_prox_s;
                out_eof_r   <= eof_prox_s;
                x_out_r     <= nx_s;
                rep_x_r     <= nrx_s;
                rep_y_r     <= nry_s;
            end else if (libera_s) begin
                out_valid_r <= 1'b0;
                x_out_r     <= LX'(0);
                rep_x_r     <= LF'(0);
                rep_y_r     <= LF'(0);
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_eol   = out_eol_r;
    assign out_eof   = out_eof_r;

endmodule

// File: tb/tb_ampliacao_pixel_escalavel.sv
// Directed bench for ampliacao_pixel_escalavel (W=4, H=2, FATOR_MAX=4) with an expected-output queue.
module tb_ampliacao_pixel_escalavel;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int FM = 4;
    localparam int LF = $clog2(FM + 1);

    typedef struct {
        logic [7:0] d;
        logic       eol;
        logic       eof;
        logic       fim;
    } esperado_t;

    logic          clk;
    logic          resetn;
    logic [LF-1:0] fator;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic          out_eol;
    logic          out_eof;

    esperado_t fila[$];
    int        checks;
    int        falhas;
    int        linhas_in;
    int        linhas_out;
    int        y_mod;
    logic      aleatorio;
    logic      stall_ant;
    logic [7:0] d_ant;
    logic      eol_ant;
    logic      eof_ant;

    ampliacao_pixel_escalavel #(
        .LARGURA_PIXEL  (8),
        .LARGURA_IMAGEM (W),
        .ALTURA_IMAGEM  (H),
        .FATOR_MAX      (FM),
        .LARGURA_MAXIMA (320)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .fator     (fator),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_eol   (out_eol),
        .out_eof   (out_eof)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        assert (obs === esp) else begin
            falhas++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, esp);
        end
    endtask

    task automatic enviar_pixel(input logic [7:0] d, input logic [LF-1:0] f);
        int espera;
        espera = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        fator    = f;
        while (in_ready !== 1'b1 && espera < 500) begin
            @(negedge clk);
            espera++;
        end
        if (espera >= 500) begin
            checks++;
            falhas++;
            $error("FAIL timeout_entrada observed=in_ready_low expected=accept_within_500");
        end
        @(posedge clk);
    endtask

    task automatic enviar_linha(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                input logic [7:0] d, input int f0, input int f1);
        logic [7:0] px [W];
        int         f;
        esperado_t  e;
        px[0] = a; px[1] = b; px[2] = c; px[3] = d;
        f = ((f0 == 0) || (f0 > FM)) ? 1 : f0;
        for (int ry = 0; ry < f; ry++) begin
            for (int x = 0; x < W; x++) begin
                for (int rx = 0; rx < f; rx++) begin
                    e.d   = px[x];
                    e.eol = (x == W - 1) && (rx == f - 1);
                    e.eof = e.eol && (ry == f - 1) && (y_mod == H - 1);
                    e.fim = e.eol && (ry == f - 1);
                    fila.push_back(e);
                end
            end
        end
        for (int x = 0; x < W; x++) begin
            enviar_pixel(px[x], (x == 0) ? LF'(f0) : LF'(f1));
        end
        linhas_in++;
        y_mod = (y_mod == H - 1) ? 0 : y_mod + 1;
    endtask

    task automatic esperar_vazio();
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (fila.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        verificar("dreno_fila", 32'(fila.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    // Output monitor: stall stability, bank occupancy vs in_ready, and scoreboard pop.
    initial begin
        esperado_t e;
        stall_ant = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn !== 1'b1) begin
                stall_ant = 1'b0;
                out_ready = 1'b1;
            end else begin
                if (stall_ant) begin
                    verificar("estavel_valid", 32'(out_valid), 32'd1);
                    verificar("estavel_data", 32'(out_data), 32'(d_ant));
                    verificar("estavel_eol", 32'(out_eol), 32'(eol_ant));
                    verificar("estavel_eof", 32'(out_eof), 32'(eof_ant));
                end
                verificar("in_ready_bancos", 32'(in_ready), 32'((linhas_in - linhas_out) < 2));
                out_ready = aleatorio ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_valid === 1'b1) begin
                    if (out_ready) begin
                        if (fila.size() == 0) begin
                            verificar("saida_extra", 32'(fila.size()), 32'd1);
                        end else begin
                            e = fila.pop_front();
                            verificar("out_data", 32'(out_data), 32'(e.d));
                            verificar("out_eol", 32'(out_eol), 32'(e.eol));
                            verificar("out_eof", 32'(out_eof), 32'(e.eof));
                            if (e.fim) begin
                                linhas_out++;
                            end
                        end
                    end
                    stall_ant = ~out_ready;
                    d_ant     = out_data;
                    eol_ant   = out_eol;
                    eof_ant   = out_eof;
                end else begin
                    stall_ant = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        checks     = 0;
        falhas     = 0;
        linhas_in  = 0;
        linhas_out = 0;
        y_mod      = 0;
        aleatorio  = 1'b0;
        out_ready  = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        fator      = LF'(1);
        resetn     = 1'b0;
        repeat (3) @(negedge clk);
        verificar("reset_out_valid", 32'(out_valid), 32'd0);
        verificar("reset_out_data", 32'(out_data), 32'd0);
        verificar("reset_out_eol", 32'(out_eol), 32'd0);
        verificar("reset_out_eof", 32'(out_eof), 32'd0);
        verificar("reset_in_ready", 32'(in_ready), 32'd1);
        resetn = 1'b1;

        // F=2 frame with first-output latency check
        enviar_linha(8'd10, 8'd20, 8'd30, 8'd40, 2, 2);
        @(negedge clk);
        in_valid = 1'b0;
        verificar("latencia_t1", 32'(out_valid), 32'd0);
        @(negedge clk);
        verificar("latencia_t2", 32'(out_valid), 32'd1);
        enviar_linha(8'd50, 8'd60, 8'd70, 8'd80, 2, 2);
        esperar_vazio();

        // F=3 frame
        enviar_linha(8'd1, 8'd2, 8'd3, 8'd4, 3, 3);
        enviar_linha(8'd5, 8'd6, 8'd7, 8'd8, 3, 3);
        esperar_vazio();

        // fator 0 and 7 sanitised to 1
        enviar_linha(8'hA1, 8'hA2, 8'hA3, 8'hA4, 0, 0);
        enviar_linha(8'hA5, 8'hA6, 8'hA7, 8'hA8, 0, 0);
        enviar_linha(8'hB1, 8'hB2, 8'hB3, 8'hB4, 7, 7);
        enviar_linha(8'hB5, 8'hB6, 8'hB7, 8'hB8, 7, 7);
        esperar_vazio();

        // fator changes mid-line: takes effect on the next line only
        enviar_linha(8'hC1, 8'hC2, 8'hC3, 8'hC4, 2, 1);
        enviar_linha(8'hC5, 8'hC6, 8'hC7, 8'hC8, 1, 1);
        esperar_vazio();

        // random backpressure over several frames and factors
        aleatorio = 1'b1;
        for (int k = 0; k < 6; k++) begin
            enviar_linha(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                         8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                         (k % 4) + 1, (k % 4) + 1);
        end
        esperar_vazio();
        aleatorio = 1'b0;
        repeat (2) @(negedge clk);

        // reset during output and after a partial input line
        enviar_linha(8'd11, 8'd12, 8'd13, 8'd14, 2, 2);
        enviar_pixel(8'd15, LF'(2));
        enviar_pixel(8'd16, LF'(2));
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        verificar("espera_saida", 32'(out_valid), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        verificar("reset2_out_valid", 32'(out_valid), 32'd0);
        verificar("reset2_out_data", 32'(out_data), 32'd0);
        verificar("reset2_out_eol", 32'(out_eol), 32'd0);
        verificar("reset2_out_eof", 32'(out_eof), 32'd0);
        verificar("reset2_in_ready", 32'(in_ready), 32'd1);
        fila.delete();
        linhas_in  = 0;
        linhas_out = 0;
        y_mod      = 0;
        @(negedge clk);
        #2;
        resetn = 1'b1;
        enviar_linha(8'd1, 8'd2, 8'd3, 8'd4, 2, 2);
        enviar_linha(8'd5, 8'd6, 8'd7, 8'd8, 2, 2);
        esperar_vazio();

        $display("TB_RESULT checks=%0d failures=%0d", checks, falhas);
        $finish;
    end

endmodule
